instruction_fetch: RTL and testbench
====================================

# instruction_fetch

IF stage of the 5-stage MIPS pipeline: owns the PC register, drives the instruction-memory request/ready handshake, and writes the IF/ID pipeline register (`pc`, `inst`) that feeds the decode stage. Takes the redirect target (`pcmultiplexed`) and taken-redirect indication back from decode, and stall from the hazard unit. Handles multi-cycle memory, redirect while a fetch is in flight, and stall while a response arrives, with no lost or duplicated instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `redirect`  in  1  decode: branch/jump taken this cycle
- `redirect_pc`  in  32  redirect target (`pcmultiplexed`); bits [1:0] forced to 00 internally
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch word address
- `imem_ready`  in  1  memory: `imem_rdata` valid, transaction completes this edge
- `imem_rdata`  in  32  instruction word
- `pc_out`  out  32  IF/ID: fetch address + 4
- `inst_out`  out  32  IF/ID: instruction (0 = nop on bubble/flush)
- `inst_valid`  out  1  IF/ID: entry holds a real instruction

## Operation
- Registers: `fetch_addr` (drives `imem_addr`), `pend_pc`, 32-bit `buf`, FSM {FETCH, DRAIN, HOLD}, IF/ID (`pc_out`, `inst_out`, `inst_valid`).
- Handshake: while `imem_req`=1, `imem_addr` must not change until a cycle with `imem_ready`=1; `imem_ready` while `imem_req`=0 is ignored. `imem_req` may stay high back-to-back, new address the cycle after completion.
- FETCH: `imem_req`=1.
  - ready & redirect: discard `imem_rdata`; `fetch_addr`<=`redirect_pc`; stay FETCH.
  - ready & stall: `buf`<=`imem_rdata`; go HOLD.
  - ready, neither: IF/ID loads {`fetch_addr`+4, `imem_rdata`, 1}; `fetch_addr`+=4.
  - not ready & redirect: `pend_pc`<=`redirect_pc`; go DRAIN.
  - not ready, no redirect: remain.
- DRAIN: `imem_req`=1, old address held. A further redirect overwrites `pend_pc` (latest wins). On ready: discard data, `fetch_addr`<=`pend_pc`, go FETCH.
- HOLD: `imem_req`=0.
  - redirect: drop `buf`, `fetch_addr`<=`redirect_pc`, go FETCH.
  - stall low: IF/ID loads {`fetch_addr`+4, `buf`, 1}, `fetch_addr`+=4, go FETCH.
- IF/ID update priority, every edge:
  - redirect: flush to {0, 0, 0}.
  - else stall: hold.
  - else delivery (FETCH ready, or HOLD release): load.
  - else: bubble {0, 0, 0}.
- Arithmetic: `fetch_addr`+4 is modulo 2^32; 0xFFFF_FFFC wraps to 0.
- Simultaneous redirect and stall: redirect wins. The hazard unit does not assert both, but the block must be deterministic.

## Timing
- Reset (async assert): state FETCH, `fetch_addr`=`RESET_PC`, `pend_pc`=0, `buf`=0, `pc_out`=0, `inst_out`=0, `inst_valid`=0, `imem_req`=0.
- After release: `imem_req`=1 from the first cycle.
- Reset asserted mid-transaction abandons it. Memory must accept the request dropping.
- `imem_req` and `imem_addr` are decoded from registers only; there is no combinational path from inputs.
- Latency: request issued in cycle N with ready in cycle N+k → IF/ID valid after the edge ending cycle N+k.
- Throughput: with a zero-wait memory, 1 instruction per cycle.
- Taken redirect with zero-wait memory: exactly 1 bubble. The in-flight word is discarded and the target fetch starts the next cycle.
- Redirect during a k-wait fetch: remaining wait cycles are wasted, then the target is fetched.
- Stall release from HOLD: the buffered word enters IF/ID on the first edge with stall low; the next fetch starts the same cycle.

## Test plan
- Reset, `RESET_PC`=0, ready tied 1, mem[i]=0x1000_0000+i → `imem_addr` 0,4,8,…; `inst_out` 0x1000_0000, 0x1000_0001, …; `pc_out` 4,8,…; `inst_valid` continuous after the first edge.
- Ready low 2 cycles per fetch → `imem_addr` stable 3 cycles; `inst_valid` one pulse per 3 cycles; `inst_out`=0 in bubbles.
- Ready=1, redirect to 0x40 in the cycle fetching 0x8 → word at 0x8 never valid; 1-cycle bubble; next `imem_addr`=0x40; next valid `pc_out`=0x44.
- Redirect to 0x80 during wait on 0x10, then redirect to 0x90 a cycle later → 0x10 held until ready, then discarded; next `imem_addr`=0x90, 0x80 never fetched.
- Stall held 3 cycles when the word at 0x20 returns → IF/ID frozen, `imem_req`=0 for 3 cycles, word 0x20 delivered once with `pc_out`=0x24, then fetch of 0x24.
- `RESET_PC`=0xFFFF_FFFC → first `pc_out`=0, next `imem_addr`=0. Then `rst_n` low mid-wait → outputs zero immediately; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage of a 5-stage MIPS pipeline.
// Owns the PC, runs the instruction-memory req/ready handshake, and writes the
// IF/ID pipeline register consumed by decode.
//
// Ports:
//   clk, rst_n              pipeline clock, async active-low reset
//   stall                   hazard unit: hold PC and IF/ID
//   redirect, redirect_pc   decode: taken branch/jump and its target
//   imem_req, imem_addr     fetch request and word address (registered)
//   imem_ready, imem_rdata  memory completion strobe and instruction word
//   pc_out, inst_out        IF/ID: fetch address + 4 and instruction
//   inst_valid              IF/ID: entry holds a real instruction
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {StFetch, StDrain, StHold} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic        valid_q, valid_d;

  logic        deliver;
  logic [31:0] deliver_inst;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target = {redirect_pc[31:2], 2'b00};
  assign pc_inc = fetch_addr_q + 32'd4;  // wraps modulo 2^32

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pend_pc_d    = pend_pc_q;
    inst_buf_d   = inst_buf_q;
    deliver      = 1'b0;
    deliver_inst = imem_rdata;

    unique case (state_q)
      StFetch: begin
        // req_q is low only in the first cycle after reset; ready is ignored then.
        if (req_q && imem_ready) begin
          if (redirect) begin
            fetch_addr_d = target;
          end else if (stall) begin
            inst_buf_d = imem_rdata;
            state_d    = StHold;
          end else begin
            deliver      = 1'b1;
            fetch_addr_d = pc_inc;
          end
        end else if (redirect) begin
          if (req_q) begin
            // Address must stay put until the in-flight fetch completes.
            pend_pc_d = target;
            state_d   = StDrain;
          end else begin
            fetch_addr_d = target;
          end
        end
      end
      StDrain: begin
        if (redirect) pend_pc_d = target;
        if (imem_ready) begin
          // A redirect on the completing edge is the latest one and wins.
          fetch_addr_d = redirect ? target : pend_pc_q;
          state_d      = StFetch;
        end
      end
      StHold: begin
        if (redirect) begin
          fetch_addr_d = target;
          state_d      = StFetch;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_inst = inst_buf_q;
          fetch_addr_d = pc_inc;
          state_d      = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    req_d = (state_d != StHold);

    if (redirect) begin
      pc_out_d   = 32'd0;
      inst_out_d = 32'd0;
      valid_d    = 1'b0;
    end else if (stall) begin
      pc_out_d   = pc_out_q;
      inst_out_d = inst_out_q;
      valid_d    = valid_q;
    end else if (deliver) begin
      pc_out_d   = pc_inc;
      inst_out_d = deliver_inst;
      valid_d    = 1'b1;
    end else begin
      pc_out_d   = 32'd0;
      inst_out_d = 32'd0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      req_q        <= 1'b0;
      fetch_addr_q <= RESET_PC;
      pend_pc_q    <= 32'd0;
      inst_buf_q   <= 32'd0;
      pc_out_q     <= 32'd0;
      inst_out_q   <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      fetch_addr_q <= fetch_addr_d;
      pend_pc_q    <= pend_pc_d;
      inst_buf_q   <= inst_buf_d;
      pc_out_q     <= pc_out_d;
      inst_out_q   <= inst_out_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = fetch_addr_q;
  assign pc_out     = pc_out_q;
  assign inst_out   = inst_out_q;
  assign inst_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_ready;

  logic        imem_req,  imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic [31:0] pc_out,    pc_out2;
  logic [31:0] inst_out,  inst_out2;
  logic        inst_valid, inst_valid2;

  int n_checks;
  int n_pass;

  // Memory image: mem[word i] = 0x1000_0000 + i
  assign imem_rdata  = 32'h1000_0000 + (imem_addr >> 2);
  assign imem_rdata2 = 32'h1000_0000 + (imem_addr2 >> 2);

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .inst_out   (inst_out),
    .inst_valid (inst_valid)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk        (clk),
    .rst_n      (rst2_n),
    .stall      (1'b0),
    .redirect   (1'b0),
    .redirect_pc(32'd0),
    .imem_req   (imem_req2),
    .imem_addr  (imem_addr2),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata2),
    .pc_out     (pc_out2),
    .inst_out   (inst_out2),
    .inst_valid (inst_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({imem_req, imem_addr, pc_out, inst_out, inst_valid} !== {1'b0, 32'd0, 32'd0, 32'd0, 1'b0})
      $display("FAIL reset_state: got req=%b addr=%h pc=%h inst=%h v=%b, expected all zero",
               imem_req, imem_addr, pc_out, inst_out, inst_valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'd0, 1'b0})
      $display("FAIL reset_release: got req=%b addr=%h v=%b, expected req=1 addr=0 v=0",
               imem_req, imem_addr, inst_valid);
    else n_pass++;
  endtask

  task automatic test_stream();
    imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (imem_addr !== 32'(4 * i))
        $display("FAIL stream_addr[%0d]: got %h expected %h", i, imem_addr, 32'(4 * i));
      else n_pass++;
      step();
      n_checks++;
      if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'(4 * (i + 1)), 32'h1000_0000 + 32'(i)})
        $display("FAIL stream_ifid[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 i, inst_valid, pc_out, inst_out, 32'(4 * (i + 1)), 32'h1000_0000 + 32'(i));
      else n_pass++;
    end
  endtask

  // Two wait cycles per fetch, starting at 0x18
  task automatic test_wait();
    logic [31:0] a;
    for (int f = 0; f < 3; f++) begin
      a = 32'h18 + 32'(4 * f);
      for (int w = 0; w < 2; w++) begin
        imem_ready = 1'b0;
        step();
        n_checks++;
        if ({imem_req, imem_addr, inst_valid, inst_out} !== {1'b1, a, 1'b0, 32'd0})
          $display("FAIL wait_bubble[%0d.%0d]: got req=%b addr=%h v=%b inst=%h expected addr=%h",
                   f, w, imem_req, imem_addr, inst_valid, inst_out, a);
        else n_pass++;
      end
      imem_ready = 1'b1;
      step();
      n_checks++;
      if ({inst_valid, pc_out, inst_out} !== {1'b1, a + 32'd4, 32'h1000_0000 + (a >> 2)})
        $display("FAIL wait_deliver[%0d]: got v=%b pc=%h inst=%h expected pc=%h inst=%h",
                 f, inst_valid, pc_out, inst_out, a + 32'd4, 32'h1000_0000 + (a >> 2));
      else n_pass++;
    end
  endtask

  // Zero-wait redirect while fetching 0x28; target low bits must be masked off
  task automatic test_redirect();
    imem_ready = 1'b1;
    step();  // delivers 0x24
    n_checks++;
    if (imem_addr !== 32'h28)
      $display("FAIL redir_pre_addr: got %h expected 00000028", imem_addr);
    else n_pass++;
    redirect = 1'b1;
    redirect_pc = 32'h41;
    step();
    redirect = 1'b0;
    n_checks++;
    if ({inst_valid, inst_out, imem_addr} !== {1'b0, 32'd0, 32'h40})
      $display("FAIL redir_bubble: got v=%b inst=%h addr=%h expected v=0 inst=0 addr=00000040",
               inst_valid, inst_out, imem_addr);
    else n_pass++;
    step();
    n_checks++;
    if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h44, 32'h1000_0010})
      $display("FAIL redir_target: got v=%b pc=%h inst=%h expected v=1 pc=00000044 inst=10000010",
               inst_valid, pc_out, inst_out);
    else n_pass++;
  endtask

  // Redirect to 0x80 then 0x90 while 0x44 waits; 0x80 must never be fetched
  task automatic test_drain();
    imem_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect_pc = 32'h90;
    n_checks++;
    if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h44, 1'b0})
      $display("FAIL drain_hold1: got req=%b addr=%h v=%b expected req=1 addr=00000044 v=0",
               imem_req, imem_addr, inst_valid);
    else n_pass++;
    step();
    redirect = 1'b0;
    n_checks++;
    if (imem_addr !== 32'h44)
      $display("FAIL drain_hold2: got %h expected 00000044", imem_addr);
    else n_pass++;
    step();
    n_checks++;
    if ({imem_addr, inst_valid} !== {32'h44, 1'b0})
      $display("FAIL drain_hold3: got addr=%h v=%b expected addr=00000044 v=0", imem_addr, inst_valid);
    else n_pass++;
    imem_ready = 1'b1;
    step();
    n_checks++;
    if ({imem_addr, inst_valid, inst_out} !== {32'h90, 1'b0, 32'd0})
      $display("FAIL drain_discard: got addr=%h v=%b inst=%h expected addr=00000090 v=0 inst=0",
               imem_addr, inst_valid, inst_out);
    else n_pass++;
    step();
    n_checks++;
    if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h94, 32'h1000_0024})
      $display("FAIL drain_target: got v=%b pc=%h inst=%h expected v=1 pc=00000094 inst=10000024",
               inst_valid, pc_out, inst_out);
    else n_pass++;
  endtask

  // Stall for 3 edges as the word at 0x20 returns
  task automatic test_stall();
    imem_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h1C;
    step();
    redirect = 1'b0;
    step();  // delivers 0x1C, now fetching 0x20
    n_checks++;
    if ({inst_valid, pc_out, imem_addr} !== {1'b1, 32'h20, 32'h20})
      $display("FAIL stall_setup: got v=%b pc=%h addr=%h expected v=1 pc=00000020 addr=00000020",
               inst_valid, pc_out, imem_addr);
    else n_pass++;
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      n_checks++;
      if ({imem_req, inst_valid, pc_out, inst_out} !== {1'b0, 1'b1, 32'h20, 32'h1000_0007})
        $display("FAIL stall_frozen[%0d]: got req=%b v=%b pc=%h inst=%h expected req=0 v=1 pc=00000020 inst=10000007",
                 s, imem_req, inst_valid, pc_out, inst_out);
      else n_pass++;
    end
    stall = 1'b0;
    step();
    n_checks++;
    if ({inst_valid, pc_out, inst_out, imem_req, imem_addr} !== {1'b1, 32'h24, 32'h1000_0008, 1'b1, 32'h24})
      $display("FAIL stall_release: got v=%b pc=%h inst=%h req=%b addr=%h expected v=1 pc=00000024 inst=10000008 req=1 addr=00000024",
               inst_valid, pc_out, inst_out, imem_req, imem_addr);
    else n_pass++;
    step();
    n_checks++;
    if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h28, 32'h1000_0009})
      $display("FAIL stall_next: got v=%b pc=%h inst=%h expected v=1 pc=00000028 inst=10000009",
               inst_valid, pc_out, inst_out);
    else n_pass++;
  endtask

  // RESET_PC = 0xFFFF_FFFC: wrap, then reset in the middle of a wait
  task automatic test_wrap_and_reset();
    n_checks++;
    if ({imem_req2, imem_addr2, inst_valid2} !== {1'b0, 32'hFFFF_FFFC, 1'b0})
      $display("FAIL wrap_reset_state: got req=%b addr=%h v=%b expected req=0 addr=fffffffc v=0",
               imem_req2, imem_addr2, inst_valid2);
    else n_pass++;
    imem_ready = 1'b1;
    @(negedge clk);
    rst2_n = 1'b1;
    step();
    n_checks++;
    if ({imem_req2, imem_addr2} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_first_req: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req2, imem_addr2);
    else n_pass++;
    step();
    n_checks++;
    if ({inst_valid2, pc_out2, inst_out2, imem_addr2} !== {1'b1, 32'd0, 32'h4FFF_FFFF, 32'd0})
      $display("FAIL wrap_deliver: got v=%b pc=%h inst=%h addr=%h expected v=1 pc=0 inst=4fffffff addr=0",
               inst_valid2, pc_out2, inst_out2, imem_addr2);
    else n_pass++;
    imem_ready = 1'b0;
    step();
    n_checks++;
    if ({imem_req2, imem_addr2, inst_valid2} !== {1'b1, 32'd0, 1'b0})
      $display("FAIL wrap_waiting: got req=%b addr=%h v=%b expected req=1 addr=0 v=0",
               imem_req2, imem_addr2, inst_valid2);
    else n_pass++;
    #2;
    rst2_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req2, imem_addr2, pc_out2, inst_out2, inst_valid2} !== {1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0})
      $display("FAIL midwait_reset: got req=%b addr=%h pc=%h inst=%h v=%b expected req=0 addr=fffffffc rest 0",
               imem_req2, imem_addr2, pc_out2, inst_out2, inst_valid2);
    else n_pass++;
    @(negedge clk);
    rst2_n = 1'b1;
    imem_ready = 1'b1;
    step();
    n_checks++;
    if ({imem_req2, imem_addr2} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL restart_req: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req2, imem_addr2);
    else n_pass++;
    step();
    n_checks++;
    if ({inst_valid2, pc_out2, inst_out2} !== {1'b1, 32'd0, 32'h4FFF_FFFF})
      $display("FAIL restart_deliver: got v=%b pc=%h inst=%h expected v=1 pc=0 inst=4fffffff",
               inst_valid2, pc_out2, inst_out2);
    else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    rst2_n      = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ready  = 1'b1;
    #10;
    test_reset();
    test_stream();
    test_wait();
    test_redirect();
    test_drain();
    test_stall();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
